// File: rtl/alu_flag_stage_pkg.sv
// Shared constants for the ALU flag stage: default width, branch codes and
// the occupancy states of the two-entry output buffer.
package alu_flag_stage_pkg;

  localparam int DW_DEF = 16;

  localparam logic [2:0] BRCH_NONE = 3'b000;
  localparam logic [2:0] BRCH_SCO  = 3'b001;
  localparam logic [2:0] BRCH_BEQ  = 3'b010;
  localparam logic [2:0] BRCH_BGE  = 3'b011;
  localparam logic [2:0] BRCH_BLT  = 3'b100;
  localparam logic [2:0] BRCH_BNE  = 3'b101;
  localparam logic [2:0] BRCH_SLE  = 3'b110;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_flag_stage_if.sv
// Handshake and data bundle between the ALU input side, the flag stage and
// the branch-condition consumer.
interface alu_flag_stage_if
  import alu_flag_stage_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_sub;
  logic [2:0]    in_brchSig;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          sf;
  logic          zf;
  logic          of;
  logic          cf;
  logic [2:0]    out_brchSig;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_brchSig, flush, out_ready,
    output in_ready, out_valid, out_result, sf, zf, of, cf, out_brchSig
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, in_brchSig, flush, out_ready,
    input  in_ready, out_valid, out_result, sf, zf, of, cf, out_brchSig
  );
endinterface

// File: rtl/alu_flag_calc.sv
// Combinational adder/subtractor producing the result and the four
// condition flags (sign, zero, signed overflow, carry-out).
module alu_flag_calc #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] result,
  output logic          sf,
  output logic          zf,
  output logic          of,
  output logic          cf
);
  logic [DW-1:0] b_eff;
  logic [DW:0]   sum;

  // Subtraction is A + ~B + 1, so cf=1 means "no borrow".
  assign b_eff  = sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{DW{1'b0}}, sub};
  assign result = sum[DW-1:0];
  assign cf     = sum[DW];
  assign sf     = sum[DW-1];
  assign zf     = (sum[DW-1:0] == '0);
  assign of     = (a[DW-1] == b_eff[DW-1]) && (sum[DW-1] != a[DW-1]);
endmodule

// File: rtl/alu_flag_stage.sv
// Registers ALU results and flags behind a main+skid buffer so the branch
// consumer can stall without the upstream ready depending on it combinationally.
module alu_flag_stage
  import alu_flag_stage_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input logic            clk,
  input logic            rst_n,
  alu_flag_stage_if.slave bus
);
  localparam int PW = DW + 7;

  logic [DW-1:0] calc_result;
  logic          calc_sf;
  logic          calc_zf;
  logic          calc_of;
  logic          calc_cf;
  logic [PW-1:0] calc_beat;

  state_e        state_reg;
  logic          in_ready_reg;
  logic [PW-1:0] main_beat_reg;
  logic [PW-1:0] skid_beat_reg;
  logic          main_valid;
  logic          accept;
  logic          transfer;

  alu_flag_calc #(.DW(DW)) u_calc (
    .a      (bus.in_a),
    .b      (bus.in_b),
    .sub    (bus.in_sub),
    .result (calc_result),
    .sf     (calc_sf),
    .zf     (calc_zf),
    .of     (calc_of),
    .cf     (calc_cf)
  );

  // Beat layout: {brchSig, sf, zf, of, cf, result}
  assign calc_beat  = {bus.in_brchSig, calc_sf, calc_zf, calc_of, calc_cf, calc_result};
  assign main_valid = (state_reg != ST_EMPTY);
  assign accept     = bus.in_valid && in_ready_reg;
  assign transfer   = main_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b0;
      main_beat_reg <= '0;
      skid_beat_reg <= '0;
    end else if (bus.flush) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      in_ready_reg <= 1'b1;
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            main_beat_reg <= calc_beat;
            state_reg     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && transfer) begin
            main_beat_reg <= calc_beat;
          end else if (accept) begin
            skid_beat_reg <= calc_beat;
            state_reg     <= ST_FULL;
            in_ready_reg  <= 1'b0;
          end else if (transfer) begin
            state_reg <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can happen.
          if (transfer) begin
            main_beat_reg <= skid_beat_reg;
            state_reg     <= ST_ONE;
          end else begin
            in_ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.out_valid   = main_valid;
  assign bus.out_result  = main_valid ? main_beat_reg[DW-1:0] : '0;
  assign bus.cf          = main_valid & main_beat_reg[DW];
  assign bus.of          = main_valid & main_beat_reg[DW+1];
  assign bus.zf          = main_valid & main_beat_reg[DW+2];
  assign bus.sf          = main_valid & main_beat_reg[DW+3];
  assign bus.out_brchSig = main_valid ? main_beat_reg[DW+6:DW+4] : 3'b000;
endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed corner cases plus randomized traffic for alu_flag_stage, checked
// against an arithmetic reference model and a FIFO scoreboard.
module tb_alu_flag_stage;
  import alu_flag_stage_pkg::*;

  localparam int DW = 16;

  typedef struct {
    logic [15:0] result;
    logic        sf;
    logic        zf;
    logic        of;
    logic        cf;
    logic [2:0]  brch;
  } beat_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  beat_t q[$];
  logic exp_ready;

  alu_flag_stage_if #(.DW(DW)) bus ();

  alu_flag_stage #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input logic [2:0] brch);
    beat_t r;
    int ua, ub, sa, sb, full, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      full = ua - ub;
      r.cf = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub;
      r.cf = (full > 65535);
      sr   = sa + sb;
    end
    r.result = 16'(full & 32'hFFFF);
    r.of     = (sr > 32767) || (sr < -32768);
    r.zf     = (r.result == 16'h0000);
    r.sf     = r.result[15];
    r.brch   = brch;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, ".result"}, 32'(bus.out_result), 32'(q[0].result));
      chk({tag, ".sf"}, 32'(bus.sf), 32'(q[0].sf));
      chk({tag, ".zf"}, 32'(bus.zf), 32'(q[0].zf));
      chk({tag, ".of"}, 32'(bus.of), 32'(q[0].of));
      chk({tag, ".cf"}, 32'(bus.cf), 32'(q[0].cf));
      chk({tag, ".brch"}, 32'(bus.out_brchSig), 32'(q[0].brch));
    end else begin
      chk({tag, ".idle_bus"},
          32'({bus.out_result, bus.sf, bus.zf, bus.of, bus.cf, bus.out_brchSig}), 32'h0);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cycle(input string tag, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic sub, input logic [2:0] brch,
                       input logic fl, input logic rdy);
    logic acc, xfer;
    bus.in_valid   = v;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_sub     = sub;
    bus.in_brchSig = brch;
    bus.flush      = fl;
    bus.out_ready  = rdy;
    @(posedge clk);
    acc  = v && exp_ready;
    xfer = (q.size() > 0) && rdy;
    if (fl) begin
      q.delete();
    end else begin
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(model(a, b, sub, brch));
    end
    exp_ready = (q.size() < 2);
    @(negedge clk);
    check_outputs(tag);
    $display("step %s v=%0b a=%04h b=%04h sub=%0b br=%0d fl=%0b rdy=%0b -> ov=%0b res=%04h q=%0d",
             tag, v, a, b, sub, brch, fl, rdy, bus.out_valid, bus.out_result, q.size());
  endtask

  task automatic expect_const(input string tag, input logic [15:0] res, input logic s,
                              input logic z, input logic o, input logic c);
    chk({tag, ".k_valid"}, 32'(bus.out_valid), 32'h1);
    chk({tag, ".k_result"}, 32'(bus.out_result), 32'(res));
    chk({tag, ".k_flags"}, 32'({bus.sf, bus.zf, bus.of, bus.cf}), 32'({s, z, o, c}));
  endtask

  task automatic idle(input string tag, input logic rdy);
    cycle(tag, 1'b0, 16'h0, 16'h0, 1'b0, BRCH_NONE, 1'b0, rdy);
  endtask

  initial begin
    logic [15:0] ra, rb;
    checks    = 0;
    failures  = 0;
    exp_ready = 1'b0;
    rst_n     = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0;
    bus.in_brchSig = BRCH_NONE; bus.flush = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    idle("post_reset", 1'b0);
    chk("post_reset.k_ready", 32'(bus.in_ready), 32'h1);

    // Arithmetic corners, one beat at a time, drained immediately
    cycle("add_7fff_1", 1'b1, 16'h7FFF, 16'h0001, 1'b0, BRCH_BLT, 1'b0, 1'b1);
    expect_const("add_7fff_1", 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("add_ffff_1", 1'b1, 16'hFFFF, 16'h0001, 1'b0, BRCH_BEQ, 1'b0, 1'b1);
    expect_const("add_ffff_1", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle("sub_5_5", 1'b1, 16'h0005, 16'h0005, 1'b1, BRCH_BNE, 1'b0, 1'b1);
    expect_const("sub_5_5", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle("sub_3_5", 1'b1, 16'h0003, 16'h0005, 1'b1, BRCH_SLE, 1'b0, 1'b1);
    expect_const("sub_3_5", 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("sub_8000_1", 1'b1, 16'h8000, 16'h0001, 1'b1, BRCH_SCO, 1'b0, 1'b1);
    expect_const("sub_8000_1", 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("drain", 1'b1);

    // Backpressure: third beat must wait for the skid to free up
    cycle("bp_beq", 1'b1, 16'h0010, 16'h0001, 1'b0, BRCH_BEQ, 1'b0, 1'b0);
    cycle("bp_bne", 1'b1, 16'h0020, 16'h0002, 1'b0, BRCH_BNE, 1'b0, 1'b0);
    chk("bp_full.k_ready", 32'(bus.in_ready), 32'h0);
    cycle("bp_blt_held", 1'b1, 16'h0030, 16'h0003, 1'b0, BRCH_BLT, 1'b0, 1'b0);
    chk("bp_hold.k_brch", 32'(bus.out_brchSig), 32'(BRCH_BEQ));
    chk("bp_hold.k_result", 32'(bus.out_result), 32'h0011);
    cycle("bp_out_beq", 1'b1, 16'h0030, 16'h0003, 1'b0, BRCH_BLT, 1'b0, 1'b1);
    chk("bp_second.k_brch", 32'(bus.out_brchSig), 32'(BRCH_BNE));
    chk("bp_second.k_ready", 32'(bus.in_ready), 32'h1);
    cycle("bp_out_bne", 1'b1, 16'h0030, 16'h0003, 1'b0, BRCH_BLT, 1'b0, 1'b1);
    chk("bp_third.k_brch", 32'(bus.out_brchSig), 32'(BRCH_BLT));
    idle("bp_drain", 1'b1);

    // Flush from FULL with a beat offered in the same cycle
    cycle("fl_a", 1'b1, 16'h1111, 16'h0001, 1'b0, BRCH_BGE, 1'b0, 1'b0);
    cycle("fl_b", 1'b1, 16'h2222, 16'h0002, 1'b0, BRCH_SLE, 1'b0, 1'b0);
    cycle("flush", 1'b1, 16'h3333, 16'h0003, 1'b0, BRCH_SCO, 1'b1, 1'b1);
    chk("flush.k_valid", 32'(bus.out_valid), 32'h0);
    chk("flush.k_ready", 32'(bus.in_ready), 32'h1);
    idle("flush_after", 1'b1);

    // Asynchronous reset in the middle of a cycle while FULL
    cycle("rs_a", 1'b1, 16'h4444, 16'h0004, 1'b0, BRCH_BEQ, 1'b0, 1'b0);
    cycle("rs_b", 1'b1, 16'h5555, 16'h0005, 1'b1, BRCH_BNE, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_ready = 1'b0;
    check_outputs("async_rst");
    @(negedge clk);
    check_outputs("rst_held");
    rst_n = 1'b1;
    idle("rst_release", 1'b1);
    chk("rst_release.k_ready", 32'(bus.in_ready), 32'h1);

    // Randomized traffic with occasional flushes and arithmetic corners
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h7FFF;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'hFFFF;
      if ($urandom_range(0, 15) == 0) rb = ra;
      cycle($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0), ra, rb,
            1'($urandom), 3'($urandom), 1'($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_flag_stage.md
ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n; no other clock or reset is used.
REQ-002 SHALL have parameter DW, default 16, giving the operand/result width.
REQ-003 SHALL have ports, one per line, as name  direction  width  meaning:
- clk  input  1  rising-edge clock
- rst_n  input  1  async active-low reset
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat
- in_a  input  DW  operand A
- in_b  input  DW  operand B
- in_sub  input  1  1 = A-B (A+~B+1), 0 = A+B
- in_brchSig  input  3  branch code travelling with the beat
- flush  input  1  synchronous discard of all held beats
- out_valid  output  1  flag beat present
- out_ready  input  1  branch-condition consumer accepts the beat
- out_result  output  DW  registered sum/difference
- sf, zf, of, cf  output  1 each  sign, zero, signed-overflow, carry-out flags
- out_brchSig  output  3  code aligned with flags

Function
REQ-004 SHALL compute result = A+B or A+~B+1, truncated to DW bits.
REQ-005 SHALL set cf to the carry-out of bit DW-1 (for subtraction, cf=1 means no borrow).
REQ-006 SHALL set of to 1 when the operand signs into the adder match and the result sign differs.
REQ-007 SHALL set zf to 1 when result == 0, and sf to result[DW-1].
REQ-008 SHALL accept a beat when in_valid && in_ready; the beat appears on the outputs, with out_valid=1, one cycle after acceptance.
REQ-009 SHALL transfer a beat out when out_valid && out_ready.
REQ-010 SHALL hold out_* and the flags stable while out_valid=1 and out_ready=0.
REQ-011 SHALL buffer up to 2 beats as a main register plus a skid register; in_ready SHALL be registered and equal to !skid_valid.
REQ-012 SHALL, when the main register stalls and a beat is accepted, place that beat in skid; when the main register drains, skid moves to main in the same cycle.
REQ-013 SHALL, in the states EMPTY, ONE and FULL, have the following transitions:
- EMPTY->ONE on accept
- ONE->EMPTY on transfer without accept
- ONE->FULL on accept without transfer
- FULL->ONE on transfer
- accept and transfer in the same cycle leave ONE in ONE
REQ-014 SHALL preserve strict FIFO order; no beat is duplicated or dropped except by flush.
REQ-015 SHALL, when flush=1, clear both valids at the next edge; a beat offered in the same cycle is dropped; flush wins over accept and transfer.
REQ-016 SHALL drive the flags and out_result to 0 when out_valid=0.

Reset
REQ-017 SHALL, on rst_n low, immediately force out_valid=0, in_ready=0, all flags/out_result/out_brchSig=0, and both valids=0, regardless of clk.
REQ-018 SHALL raise in_ready to 1 on the first clk edge after rst_n deasserts; a beat in flight when reset asserts is lost.

Structure
REQ-019 SHALL take the shared package constants: DW default and the brchSig codes BEQ=010, BNE=101, BLT=100, BGE=011, SLE=110, SCO=001, NONE=000.
REQ-020 SHALL treat brchSig as opaque data and pass it through without decoding it.
REQ-021 SHALL contain one combinational sub-module, alu_flag_calc (operands, in_sub -> result, sf, zf, of, cf), instanced once on the input side; the buffer and state logic live in alu_flag_stage.

Verification
REQ-022 SHALL cover: add 0x7FFF+0x0001, out_ready=1 -> next cycle out_result=0x8000, sf=1, of=1, zf=0, cf=0, out_valid=1.
REQ-023 SHALL cover: add 0xFFFF+0x0001 -> out_result=0x0000, zf=1, cf=1, of=0, sf=0.
REQ-024 SHALL cover:
- sub 0x0005-0x0005 -> out_result=0x0000, zf=1, cf=1, sf=0, of=0
- sub 0x0003-0x0005 -> out_result=0xFFFE, sf=1, cf=0, of=0
- sub 0x8000-0x0001 -> out_result=0x7FFF, of=1
REQ-025 SHALL cover backpressure: out_ready=0, offer 3 beats tagged BEQ, BNE, BLT -> 2 accepted, in_ready=0 after the second; raise out_ready -> BEQ then BNE delivered on consecutive cycles, then BLT accepted.
REQ-026 SHALL cover flush: state FULL with in_valid=1 and flush=1 -> next cycle out_valid=0, in_ready=1, no beat delivered.
REQ-027 SHALL cover reset: rst_n low mid-cycle while FULL -> out_valid and flags 0 before the next edge; after release in_ready=1 within 1 cycle.
